// File: rtl/expgob_pkg.sv
// Shared definitions for the Exp-Golomb decode controller: the FSM state
// encoding, the default maximum prefix length and the width of the
// bit-index counters.
package expgob_pkg;

    // Width of the zero counter, the suffix index and the datapath bit index
    localparam int IDX_W          = 4;

    // Default maximum number of leading zeros accepted before an overflow
    localparam int MAX_PREFIX_DEF = 7;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREFIX = 2'd1,
        ST_SUFFIX = 2'd2,
        ST_OUT    = 2'd3
    } state_e;

endpackage : expgob_pkg

// File: rtl/expgob_decod_ctrl.sv
// Exp-Golomb decode controller. It consumes a serial code MSB first. It counts
// the leading zeros, and then steers the terminating 1 and the N suffix bits
// into the datapath: the bit index goes on cnt_o and the write strobe on prc_o.
// It holds the result in OUT until the consumer takes it.
// Optional build macro: EXPGOB_ERR_CNT_EN adds an 8-bit saturating count of
// prefix-overflow errors on err_cnt_o.
module expgob_decod_ctrl
    import expgob_pkg::*;
#(
    parameter int MAX_PREFIX = MAX_PREFIX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_i,
    input  logic             bit_valid_i,
    output logic             bit_ready_o,
    output logic             cod_o,
    output logic [IDX_W-1:0] cnt_o,
    output logic             prc_o,
    output logic             busy_o,
    output logic             clr_o,
    output logic             code_valid_o,
    input  logic             code_ready_i,
    output logic [IDX_W-1:0] len_o,
`ifdef EXPGOB_ERR_CNT_EN
    output logic             err_o,
    output logic [7:0]       err_cnt_o
`else
    output logic             err_o
`endif
);

    localparam logic [IDX_W-1:0] MAX_PREFIX_L = IDX_W'(MAX_PREFIX);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] zcnt_q, zcnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic             xfer;

    assign bit_ready_o  = (state_q != ST_OUT);
    assign busy_o       = (state_q != ST_OUT);
    assign code_valid_o = (state_q == ST_OUT);
    assign cod_o        = bit_i;
    assign len_o        = len_q;
    assign xfer         = bit_valid_i & bit_ready_o;

    // Next-state and per-cycle datapath controls. IDLE handles a bit exactly
    // like PREFIX does, because zcnt is always zero there.
    always_comb begin
        state_d = state_q;
        zcnt_d  = zcnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        prc_o   = 1'b0;
        cnt_o   = '0;
        clr_o   = 1'b0;
        err_o   = 1'b0;
        case (state_q)
            ST_IDLE, ST_PREFIX: begin
                if (xfer) begin
                    if (bit_i) begin
                        // Terminating 1: write it at bit position N
                        prc_o = 1'b1;
                        cnt_o = zcnt_q;
                        len_d = zcnt_q;
                        if (zcnt_q == '0) begin
                            state_d = ST_OUT;
                        end else begin
                            state_d = ST_SUFFIX;
                            idx_d   = zcnt_q - 1'b1;
                        end
                    end else if (zcnt_q == MAX_PREFIX_L) begin
                        // Prefix too long: drop the code and restart clean
                        err_o   = 1'b1;
                        clr_o   = 1'b1;
                        zcnt_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        zcnt_d  = zcnt_q + 1'b1;
                        state_d = ST_PREFIX;
                    end
                end
            end
            ST_SUFFIX: begin
                if (xfer) begin
                    prc_o = 1'b1;
                    cnt_o = idx_q;
                    if (idx_q == '0) begin
                        state_d = ST_OUT;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            ST_OUT: begin
                if (code_ready_i) begin
                    clr_o   = 1'b1;
                    zcnt_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                zcnt_d  = '0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            zcnt_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            zcnt_q  <= zcnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
        end
    end

`ifdef EXPGOB_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    assign err_cnt_o = err_cnt_q;

    // Saturating count of prefix-overflow events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (err_o && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
`endif

endmodule : expgob_decod_ctrl

// File: tb/tb_expgob_decod_ctrl.sv
// Directed bench for expgob_decod_ctrl. It contains a small model of the
// downstream datapath: the accumulator is cleared on clr_o, bit cod_o is
// written at cnt_o on prc_o, and the result is the accumulator minus one.
module tb_expgob_decod_ctrl;

    logic       clk;
    logic       rst_n;
    logic       bit_i;
    logic       bit_valid_i;
    logic       bit_ready_o;
    logic       cod_o;
    logic [3:0] cnt_o;
    logic       prc_o;
    logic       busy_o;
    logic       clr_o;
    logic       code_valid_o;
    logic       code_ready_i;
    logic [3:0] len_o;
    logic       err_o;
`ifdef EXPGOB_ERR_CNT_EN
    logic [7:0] err_cnt_o;
`endif

    int n_checks;
    int n_fails;
    logic [7:0] acc;

    expgob_decod_ctrl #(.MAX_PREFIX(7)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bit_i        (bit_i),
        .bit_valid_i  (bit_valid_i),
        .bit_ready_o  (bit_ready_o),
        .cod_o        (cod_o),
        .cnt_o        (cnt_o),
        .prc_o        (prc_o),
        .busy_o       (busy_o),
        .clr_o        (clr_o),
        .code_valid_o (code_valid_o),
        .code_ready_i (code_ready_i),
        .len_o        (len_o),
`ifdef EXPGOB_ERR_CNT_EN
        .err_o        (err_o),
        .err_cnt_o    (err_cnt_o)
`else
        .err_o        (err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr_o) begin
            acc <= '0;
        end else if (prc_o) begin
            acc[cnt_o[2:0]] <= cod_o;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        logic [15:0] bits;        // code, first bit at position nbits-1
        int          nbits;
        bit          bubble;      // idle cycle between bits
        int          ready_delay; // cycles in OUT before code_ready_i
        int          exp_len;
        int          exp_val;
        logic [31:0] exp_cnt;     // write indices, first one in lowest nibble
    } vec_t;

    vec_t vecs[6];

    // Presents one bit for one cycle. Combinational outputs are sampled just
    // after the negedge, and the transfer happens on the following posedge.
    task automatic send_bit(input logic b, input bit exp_prc, input int exp_cnt, input string tag);
        @(negedge clk);
        bit_i       = b;
        bit_valid_i = 1'b1;
        #1;
        check({tag, " ready"}, int'(bit_ready_o), 1);
        check({tag, " prc"}, int'(prc_o), int'(exp_prc));
        if (exp_prc) check({tag, " cnt"}, int'(cnt_o), exp_cnt);
        check({tag, " err"}, int'(err_o), 0);
    endtask

    task automatic bubble_cycle(input string tag);
        @(negedge clk);
        bit_valid_i = 1'b0;
        #1;
        check({tag, " bubble prc"}, int'(prc_o), 0);
    endtask

    // Waits in OUT for ready_delay cycles, then hands the code over and checks
    // the result.
    task automatic finish_code(input int ready_delay, input int exp_len, input int exp_val, input string tag);
        @(negedge clk);
        bit_valid_i = 1'b0;
        #1;
        check({tag, " code_valid"}, int'(code_valid_o), 1);
        check({tag, " busy"}, int'(busy_o), 0);
        check({tag, " len"}, int'(len_o), exp_len);
        for (int d = 0; d < ready_delay; d++) begin
            @(negedge clk);
            #1;
            check({tag, " hold valid"}, int'(code_valid_o), 1);
            check({tag, " hold ready"}, int'(bit_ready_o), 0);
            check({tag, " hold clr"}, int'(clr_o), 0);
            check({tag, " hold len"}, int'(len_o), exp_len);
        end
        code_ready_i = 1'b1;
        #1;
        check({tag, " clr"}, int'(clr_o), 1);
        check({tag, " value"}, int'(acc) - 1, exp_val);
        @(negedge clk);
        code_ready_i = 1'b0;
        #1;
        check({tag, " idle valid"}, int'(code_valid_o), 0);
        check({tag, " idle busy"}, int'(busy_o), 1);
    endtask

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        rst_n        = 1'b0;
        bit_i        = 1'b0;
        bit_valid_i  = 1'b0;
        code_ready_i = 1'b0;

        //           bits                   n   bub dly len val cnts
        vecs[0] = '{16'b1,                  1,  0,  0,  0,  0,   32'h0000_0000};
        vecs[1] = '{16'b010,                3,  0,  0,  1,  1,   32'h0000_0001};
        vecs[2] = '{16'b00111,              5,  1,  0,  2,  6,   32'h0000_0012};
        vecs[3] = '{16'b010,                3,  0,  5,  1,  1,   32'h0000_0001};
        vecs[4] = '{16'b0001010,            7,  0,  0,  3,  9,   32'h0000_0123};
        vecs[5] = '{16'b000000011111111,    15, 1,  2,  7,  254, 32'h0123_4567};

        repeat (3) @(negedge clk);
        #1;
        check("reset code_valid", int'(code_valid_o), 0);
        check("reset len", int'(len_o), 0);
        check("reset prc", int'(prc_o), 0);
        check("reset cnt", int'(cnt_o), 0);
        check("reset clr", int'(clr_o), 0);
        check("reset err", int'(err_o), 0);
        check("reset busy", int'(busy_o), 1);
        check("reset ready", int'(bit_ready_o), 1);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            int wr;
            logic [15:0] bits;
            logic [31:0] cnts;
            string tag;
            bits = vecs[v].bits;
            cnts = vecs[v].exp_cnt;
            tag  = $sformatf("vec%0d", v);
            wr   = 0;
            for (int k = vecs[v].nbits - 1; k >= 0; k--) begin
                bit is_wr;
                is_wr = ((vecs[v].nbits - 1 - k) >= vecs[v].exp_len);
                send_bit(bits[k], is_wr, int'(cnts[4*wr +: 4]), tag);
                if (is_wr) wr++;
                if (vecs[v].bubble && k != 0) bubble_cycle(tag);
            end
            finish_code(vecs[v].ready_delay, vecs[v].exp_len, vecs[v].exp_val, tag);
            $display("vec%0d: %0d bits, len %0d, value %0d", v, vecs[v].nbits, int'(len_o), int'(acc) - 1);
        end

        // Prefix overflow: the eighth zero raises err_o and clr_o with no write
        for (int k = 0; k < 7; k++) send_bit(1'b0, 1'b0, 0, "ovf");
        @(negedge clk);
        bit_i       = 1'b0;
        bit_valid_i = 1'b1;
        #1;
        check("ovf err", int'(err_o), 1);
        check("ovf clr", int'(clr_o), 1);
        check("ovf prc", int'(prc_o), 0);
        @(negedge clk);
        bit_valid_i = 1'b0;
        #1;
        check("ovf err gone", int'(err_o), 0);
        check("ovf no valid", int'(code_valid_o), 0);
        // Back in IDLE: a lone "1" decodes as length 0
        send_bit(1'b1, 1'b1, 0, "post-ovf");
        finish_code(0, 0, 0, "post-ovf");
        $display("overflow: err pulse seen, following code value %0d", int'(acc) - 1);

        // Reset in the middle of a suffix, then "011" decodes as 2
        send_bit(1'b0, 1'b0, 0, "midrst");
        send_bit(1'b0, 1'b0, 0, "midrst");
        send_bit(1'b1, 1'b1, 2, "midrst");
        send_bit(1'b0, 1'b1, 1, "midrst");
        @(negedge clk);
        bit_valid_i = 1'b0;
        rst_n       = 1'b0;
        #1;
        check("midrst valid", int'(code_valid_o), 0);
        check("midrst len", int'(len_o), 0);
        check("midrst prc", int'(prc_o), 0);
        check("midrst cnt", int'(cnt_o), 0);
        check("midrst clr", int'(clr_o), 0);
        check("midrst busy", int'(busy_o), 1);
        @(negedge clk);
        rst_n = 1'b1;
        send_bit(1'b0, 1'b0, 0, "afterrst");
        send_bit(1'b1, 1'b1, 1, "afterrst");
        send_bit(1'b1, 1'b1, 0, "afterrst");
        finish_code(0, 1, 2, "afterrst");
        $display("reset mid-code: following code value %0d", int'(acc) - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_expgob_decod_ctrl
